// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: single-cycle MULT/MULTU/MTHI/MTLO, 32-step restoring DIV/DIVU.
// Optional build macro DIV_ZERO_FAST_EN: divide by zero completes at the accept edge instead of running 32 steps.
module mdu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  op,
    input  logic        valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_n;
    logic [4:0]  cnt;
    logic [31:0] rem_q, quo_q, dvs_q;
    logic        neg_quo_q, neg_rem_q;

    logic        accept, is_div, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [63:0] prod_s, prod_u;
    logic [32:0] trial, diff;
    logic        fit;
    logic [31:0] rem_n, quo_n, res_hi, res_lo;

    assign accept = (state == IDLE) && valid && !flush;
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign a_neg  = (op == OP_DIV) && a[31];
    assign b_neg  = (op == OP_DIV) && b[31];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // quo_q starts as the dividend; its MSB shifts into the partial remainder while quotient bits fill from the right.
    assign trial  = {rem_q, quo_q[31]};
    assign diff   = trial - {1'b0, dvs_q};
    assign fit    = !diff[32];
    assign rem_n  = fit ? diff[31:0] : trial[31:0];
    assign quo_n  = {quo_q[30:0], fit};
    assign res_lo = neg_quo_q ? -quo_n : quo_n;
    assign res_hi = neg_rem_q ? -rem_n : rem_n;

`ifdef DIV_ZERO_FAST_EN
    // Divide by zero: quotient all ones before fixup; the fixed-up remainder is simply a itself.
    logic [31:0] dz_lo;
    assign dz_lo = (a_neg ^ b_neg) ? 32'd1 : 32'hFFFF_FFFF;
`endif

    always_comb begin
        state_n = state;
        stall   = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_div) begin
                    stall   = 1'b1;
                    state_n = RUN;
`ifdef DIV_ZERO_FAST_EN
                    if (b == 32'd0) state_n = DONE;
`endif
                end
            end
            RUN: begin
                stall = 1'b1;
                if (cnt == 5'd31) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush || rst) begin
            state_n = IDLE;
            stall   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            busy      <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvs_q     <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n == RUN);
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT:  {hi, lo} <= prod_s;
                            OP_MULTU: {hi, lo} <= prod_u;
                            OP_MTHI:  hi <= a;
                            OP_MTLO:  lo <= a;
                            OP_DIV, OP_DIVU: begin
                                rem_q     <= 32'd0;
                                quo_q     <= a_mag;
                                dvs_q     <= b_mag;
                                neg_quo_q <= a_neg ^ b_neg;
                                neg_rem_q <= a_neg;
                                cnt       <= 5'd0;
`ifdef DIV_ZERO_FAST_EN
                                if (b == 32'd0) begin
                                    hi <= a;
                                    lo <= dz_lo;
                                end
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (!flush) begin
                        rem_q <= rem_n;
                        quo_q <= quo_n;
                        cnt   <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus randomized ops against an arithmetic reference model.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst, valid, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        stall, busy;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [63:0] m;  // model {hi, lo}

`ifdef DIV_ZERO_FAST_EN
    localparam int DZ_STALL = 1;
`else
    localparam int DZ_STALL = 33;
`endif

    mdu_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .valid(valid), .a(a), .b(b),
        .flush(flush), .stall(stall), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        valid = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; flush = 1'b0;
    endtask

    // Reference model: results from plain integer arithmetic on the architectural rules.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] cur,
                                          input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] res;
        logic [31:0] uq, ur;
        res = cur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd1: res = 64'(sx * sy);
            3'd2: res = {32'd0, x} * {32'd0, y};
            3'd3: begin
                if (y == 32'd0) begin
                    uq = 32'hFFFF_FFFF;
                    ur = x[31] ? -x : x;
                    if (x[31]) uq = -uq;
                    if (x[31]) ur = -ur;
                    res = {ur, uq};
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd4: res = (y == 32'd0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            3'd5: res = {x, cur[31:0]};
            3'd6: res = {cur[63:32], x};
            default: res = cur;
        endcase
        return res;
    endfunction

    // Hold a divide on the inputs and count stall cycles; returns in the cycle where stall drops.
    task automatic run_div(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           output int n);
        valid = 1'b1; op = o; a = x; b = y; flush = 1'b0;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        valid = 1'b1; op = o; a = x; b = y; flush = 1'b0;
        tick();
        idle_inputs();
        m = model(o, m, x, y);
    endtask

    task automatic test_reset;
        rst = 1'b1; valid = 1'b1; op = 3'd3; a = 32'd7; b = 32'd1; flush = 1'b0;
        tick();
        tick();
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
        rst = 1'b0;
        idle_inputs();
        tick();
        m = 64'd0;
    endtask

    task automatic test_mult;
        valid = 1'b1; op = 3'd1; a = 32'hFFFF_FFFE; b = 32'd3;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL mult_stall: got %b expected 0", stall); end
        tick();
        idle_inputs();
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
            errors++; $display("FAIL mult_signed: got %h expected ffffffff_fffffffa", {hi, lo});
        end
        issue(3'd2, 32'hFFFF_FFFE, 32'd3);
        checks++;
        if ({hi, lo} !== 64'h0000_0002_FFFF_FFFA) begin
            errors++; $display("FAIL multu: got %h expected 00000002_fffffffa", {hi, lo});
        end
    endtask

    task automatic test_divu_timing;
        int n;
        run_div(3'd4, 32'd100, 32'd7, n);
        checks++;
        if (n !== 33) begin errors++; $display("FAIL divu_stall_cycles: got %0d expected 33", n); end
        checks++;
        if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_result: got %h expected 2/14", {hi, lo}); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL divu_done_busy: got %b expected 0", busy); end
        // DONE must ignore a new op presented while it is still valid.
        op = 3'd5; a = 32'h0000_0BAD;
        tick();
        checks++;
        if (hi !== 32'd2) begin errors++; $display("FAIL done_ignores_op: got %h expected 2", hi); end
        // Now in IDLE: a MULT must be accepted immediately.
        op = 3'd1; a = 32'd3; b = 32'd5;
        tick();
        idle_inputs();
        checks++;
        if ({hi, lo} !== 64'd15) begin errors++; $display("FAIL idle_after_done: got %h expected 15", {hi, lo}); end
        m = 64'd15;
    endtask

    task automatic test_div_signed;
        int n;
        run_div(3'd3, 32'hFFFF_FFF9, 32'd2, n);
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            errors++; $display("FAIL div_neg7_2: got %h expected ffffffff_fffffffd", {hi, lo});
        end
        idle_inputs(); tick();
        run_div(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        checks++;
        if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
            errors++; $display("FAIL div_overflow: got %h expected 00000000_80000000", {hi, lo});
        end
        idle_inputs(); tick();
        m = {hi, lo};
    endtask

    task automatic test_div_zero;
        int n;
        run_div(3'd3, 32'd7, 32'd0, n);
        checks++;
        if (n !== DZ_STALL) begin errors++; $display("FAIL div0_stall_cycles: got %0d expected %0d", n, DZ_STALL); end
        checks++;
        if ({hi, lo} !== 64'h0000_0007_FFFF_FFFF) begin
            errors++; $display("FAIL div0_result: got %h expected 00000007_ffffffff", {hi, lo});
        end
        idle_inputs(); tick();
        run_div(3'd3, 32'hFFFF_FFF9, 32'd0, n);
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFF9_0000_0001) begin
            errors++; $display("FAIL div0_neg: got %h expected fffffff9_00000001", {hi, lo});
        end
        idle_inputs(); tick();
        m = {hi, lo};
    endtask

    task automatic test_flush;
        issue(3'd5, 32'h0000_1234, 32'd0);
        issue(3'd6, 32'h0000_0055, 32'd0);
        valid = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 3) begin op = 3'd5; a = 32'h0000_DEAD; end
            if (k == 5) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL run_busy: got %b expected 1", busy); end
            end
        end
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", stall); end
        tick();
        idle_inputs();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
        checks++;
        if ({hi, lo} !== 64'h0000_1234_0000_0055) begin
            errors++; $display("FAIL flush_hilo: got %h expected 00001234_00000055", {hi, lo});
        end
        // Flush in IDLE blocks acceptance.
        valid = 1'b1; op = 3'd3; a = 32'd9; b = 32'd2; flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %b expected 0", stall); end
        op = 3'd5; a = 32'h0000_AAAA;
        tick();
        idle_inputs();
        checks++;
        if (hi !== 32'h0000_1234 || busy !== 1'b0) begin
            errors++; $display("FAIL flush_idle_block: got hi=%h busy=%b expected 00001234/0", hi, busy);
        end
        issue(3'd6, 32'h0000_0077, 32'd0);
        checks++;
        if (lo !== 32'h0000_0077) begin errors++; $display("FAIL idle_after_flush: got %h expected 77", lo); end
    endtask

    task automatic test_reset_mid_div;
        issue(3'd5, 32'h11, 32'd0);
        issue(3'd6, 32'h22, 32'd0);
        valid = 1'b1; op = 3'd3; a = 32'd50; b = 32'd3;
        for (int k = 1; k <= 5; k++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b expected 0", stall); end
        tick();
        rst = 1'b0;
        idle_inputs();
        checks++;
        if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin
            errors++; $display("FAIL rst_mid_state: got busy=%b hilo=%h expected 0/0", busy, {hi, lo});
        end
        m = 64'd0;
        issue(3'd1, 32'd3, 32'd4);
        checks++;
        if ({hi, lo} !== 64'd12) begin errors++; $display("FAIL rst_then_mult: got %h expected 12", {hi, lo}); end
    endtask

    task automatic test_random;
        logic [2:0]  o;
        logic [31:0] x, y;
        logic [63:0] exp_v;
        int n;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: x = 32'h8000_0000;
                1: x = 32'hFFFF_FFFF;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            exp_q.push_back(model(o, m, x, y));
            if (o == 3'd3 || o == 3'd4) begin
                run_div(o, x, y, n);
                checks++;
                if (n !== ((y == 32'd0) ? DZ_STALL : 33)) begin
                    errors++; $display("FAIL rand_div_stall[%0d]: got %0d cycles op=%0d b=%h", i, n, o, y);
                end
                idle_inputs();
                tick();
            end else begin
                valid = 1'b1; op = o; a = x; b = y;
                #1;
                checks++;
                if (stall !== 1'b0) begin errors++; $display("FAIL rand_nodiv_stall[%0d]: got %b expected 0", i, stall); end
                tick();
                idle_inputs();
            end
            exp_v = exp_q.pop_front();
            checks++;
            if ({hi, lo} !== exp_v) begin
                errors++; $display("FAIL rand_result[%0d]: op=%0d a=%h b=%h got %h expected %h", i, o, x, y, {hi, lo}, exp_v);
            end
            m = exp_v;
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        m = 64'd0;
        test_reset();
        test_mult();
        test_divu_timing();
        test_div_signed();
        test_div_zero();
        test_flush();
        test_reset_mid_div();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
